// File: rtl/exc_redirect_ctrl_pkg.sv
// Shared definitions for the exception/ERET redirect controller: FSM encoding,
// default exception vector, MIPS ExcCode constants and a saturating increment.
package exc_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } exc_state_e;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

  localparam logic [4:0] EXCCODE_INT  = 5'd0;
  localparam logic [4:0] EXCCODE_ADEL = 5'd4;
  localparam logic [4:0] EXCCODE_ADES = 5'd5;
  localparam logic [4:0] EXCCODE_SYS  = 5'd8;
  localparam logic [4:0] EXCCODE_BP   = 5'd9;
  localparam logic [4:0] EXCCODE_RI   = 5'd10;
  localparam logic [4:0] EXCCODE_OV   = 5'd12;

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? 16'hFFFF : val + 16'd1;
  endfunction

endpackage

// File: rtl/exc_redirect_ctrl_if.sv
// Redirect channel from the controller to fetch: PC plus valid/ready handshake.
interface exc_redirect_ctrl_if;

  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_ready;

  modport master (
    output redirect_valid,
    output redirect_pc,
    input  if_ready
  );

  modport slave (
    input  redirect_valid,
    input  redirect_pc,
    output if_ready
  );

endinterface

// File: rtl/exc_redirect_ctrl_sat_counter16.sv
// 16-bit event counter that sticks at 16'hFFFF; clr_i has priority over en_i.
module sat_counter16
  import exc_redirect_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        clr_i,
  input  logic        en_i,
  output logic [15:0] cnt_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 16'd0;
    end else if (en_i) begin
      cnt_d = sat_inc16(cnt_q);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/exc_redirect_ctrl.sv
// Exception/ERET redirect controller: flushes younger stages, then holds the
// redirect PC for fetch. Define EXC_REDIRECT_STATS_EN to build the request counters.
module exc_redirect_ctrl
  import exc_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned NSTAGE       = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                exc_req_i,
  input  logic [4:0]          exc_code_i,
  input  logic                exc_bd_i,
  input  logic                eret_req_i,
  input  logic [31:0]         epc_i,
  input  logic                pause_i,
  exc_redirect_ctrl_if.master redir,
  output logic [NSTAGE-1:0]   flush_o,
  output logic                busy_o,
  output logic [4:0]          last_code_o,
  output logic                last_bd_o,
  output logic [15:0]         exc_count_o,
  output logic [15:0]         eret_count_o
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  exc_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       pc_q, pc_d;
  logic [4:0]        code_q, code_d;
  logic              bd_q, bd_d;
  logic [NSTAGE-1:0] flush_q, flush_d;
  logic              rv_q, rv_d;
  logic              busy_q, busy_d;
  logic              accept_s;

  // Requests are only taken from IDLE; anything arriving while paused is dropped.
  assign accept_s = (state_q == ST_IDLE) & (exc_req_i | eret_req_i) & ~pause_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    code_d  = code_q;
    bd_d    = bd_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          cnt_d   = FLUSH_LOAD;
          state_d = ST_FLUSH;
          if (exc_req_i) begin
            pc_d   = EXC_VECTOR;
            code_d = exc_code_i;
            bd_d   = exc_bd_i;
          end else begin
            pc_d = epc_i;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_REDIRECT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_REDIRECT: begin
        if (rv_q & redir.if_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REDIRECT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Outputs are decoded from the next state so they come straight off flops.
    flush_d = {NSTAGE{state_d == ST_FLUSH}};
    rv_d    = (state_d == ST_REDIRECT);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      pc_q    <= 32'd0;
      code_q  <= 5'd0;
      bd_q    <= 1'b0;
      flush_q <= '0;
      rv_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      code_q  <= code_d;
      bd_q    <= bd_d;
      flush_q <= flush_d;
      rv_q    <= rv_d;
      busy_q  <= busy_d;
    end
  end

  assign flush_o              = flush_q;
  assign busy_o               = busy_q;
  assign last_code_o          = code_q;
  assign last_bd_o            = bd_q;
  assign redir.redirect_valid = rv_q;
  assign redir.redirect_pc    = pc_q;

`ifdef EXC_REDIRECT_STATS_EN
  // exc_req takes priority, so a simultaneous ERET is not counted.
  sat_counter16 u_exc_cnt (
    .clk   (clk),
    .clr_i (rst),
    .en_i  (accept_s & exc_req_i),
    .cnt_o (exc_count_o)
  );

  sat_counter16 u_eret_cnt (
    .clk   (clk),
    .clr_i (rst),
    .en_i  (accept_s & ~exc_req_i & eret_req_i),
    .cnt_o (eret_count_o)
  );
`else
  assign exc_count_o  = 16'd0;
  assign eret_count_o = 16'd0;
`endif

endmodule
